// File: rtl/sprite_datapath.sv
// ---------------------------------------------------------------------------
// sprite_datapath
//   Square sprite generator for a VGA frame-buffer adapter. Keeps the sprite
//   origin and its bounce direction on each axis. While wren is high it sweeps
//   the SIZE x SIZE sprite row-major, emitting one registered pixel per cycle.
//
// Parameters
//   SIZE     sprite side in pixels (power of two, 2..16)
//   X_START  x origin loaded on reset / init
//   Y_START  y origin loaded on reset / init
//   X_MAX    screen width  (X_START + SIZE <= X_MAX)
//   Y_MAX    screen height (Y_START + SIZE <= Y_MAX)
//
// Ports
//   clk         single clock, all state on the rising edge
//   resetn      synchronous reset, active HIGH despite the name
//   init        reload origin and set both directions to increasing
//   move        one-cycle strobe: step the origin one pixel on each axis
//   wren        sweep enable: one sprite pixel per cycle
//   draw_color  colour for emitted pixels (000 erases)
//   x, y        registered pixel coordinate
//   colour      registered pixel colour
//   plot        registered pixel write strobe
//   finish      combinational: the last pixel of the sweep is issued this cycle
// ---------------------------------------------------------------------------
module sprite_datapath #(
  parameter int SIZE    = 4,
  parameter int X_START = 0,
  parameter int Y_START = 0,
  parameter int X_MAX   = 160,
  parameter int Y_MAX   = 120
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       init,
  input  logic       move,
  input  logic       wren,
  input  logic [2:0] draw_color,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       finish
);

  localparam int LW = $clog2(SIZE);
  localparam int CW = 2 * LW;

  // SIZE is a power of two, so the final sweep index is all ones.
  localparam logic [CW-1:0] CNT_LAST = {CW{1'b1}};
  localparam logic [7:0]    X0       = 8'(X_START);
  localparam logic [6:0]    Y0       = 7'(Y_START);
  localparam logic [8:0]    XLIM     = 9'(X_MAX);
  localparam logic [8:0]    YLIM     = 9'(Y_MAX);
  localparam logic [8:0]    SZ       = 9'(SIZE);

  logic [7:0]    pos_x;
  logic [6:0]    pos_y;
  logic          dir_x;
  logic          dir_y;
  logic [CW-1:0] cnt;

  logic [LW-1:0] dx;
  logic [LW-1:0] dy;

  logic [7:0]    x_p1;
  logic [6:0]    y_p1;
  logic [2:0]    colour_p1;
  logic          vld_p1;

  // Bounce on the x axis. Returns {dir_next, pos_next}. Reaching the far edge
  // (sprite's right side touching the screen edge) reverses and steps back in
  // the same cycle, so the sprite never leaves the screen.
  function automatic logic [8:0] step_x(input logic [7:0] pos, input logic dir);
    logic [8:0] far;
    far = {1'b0, pos} + SZ;
    if (dir && (far == XLIM))
      return {1'b0, pos - 8'd1};
    else if (!dir && (pos == 8'd0))
      return {1'b1, pos + 8'd1};
    else if (dir)
      return {1'b1, pos + 8'd1};
    else
      return {1'b0, pos - 8'd1};
  endfunction

  // Same bounce rule for the 7-bit y axis. Returns {dir_next, pos_next}.
  function automatic logic [7:0] step_y(input logic [6:0] pos, input logic dir);
    logic [8:0] far;
    far = {2'b00, pos} + SZ;
    if (dir && (far == YLIM))
      return {1'b0, pos - 7'd1};
    else if (!dir && (pos == 7'd0))
      return {1'b1, pos + 7'd1};
    else if (dir)
      return {1'b1, pos + 7'd1};
    else
      return {1'b0, pos - 7'd1};
  endfunction

  // Sweep counter: low half is the column, high half the row, so the column
  // runs fastest and the sweep is row-major.
  assign dx = cnt[LW-1:0];
  assign dy = cnt[CW-1:LW];

  assign finish = wren & (cnt == CNT_LAST) & ~resetn;

  // ---- stage p0 -> p1: origin/direction update and pixel register --------
  always_ff @(posedge clk) begin
    if (resetn) begin
      pos_x     <= X0;
      pos_y     <= Y0;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      cnt       <= '0;
      x_p1      <= '0;
      y_p1      <= '0;
      colour_p1 <= '0;
      vld_p1    <= 1'b0;
    end else begin
      // Pixel uses the origin as it stood before any move in this cycle.
      if (wren) begin
        x_p1      <= pos_x + {{(8-LW){1'b0}}, dx};
        y_p1      <= pos_y + {{(7-LW){1'b0}}, dy};
        colour_p1 <= draw_color;
        vld_p1    <= 1'b1;
        cnt       <= cnt + CW'(1);
      end else begin
        cnt    <= '0;
        vld_p1 <= 1'b0;
      end

      if (init) begin
        pos_x <= X0;
        pos_y <= Y0;
        dir_x <= 1'b1;
        dir_y <= 1'b1;
      end else if (move) begin
        {dir_x, pos_x} <= step_x(pos_x, dir_x);
        {dir_y, pos_y} <= step_y(pos_y, dir_y);
      end
    end
  end

  // ---- stage p1: registered outputs -------------------------------------
  assign x      = x_p1;
  assign y      = y_p1;
  assign colour = colour_p1;
  assign plot   = vld_p1;

endmodule

// File: tb/tb_sprite_datapath.sv
module tb_sprite_datapath;

  localparam int S = 4;
  localparam int XM = 160;
  localparam int YM = 120;

  logic       clk = 1'b0;
  logic       resetn = 1'b1;
  logic       init = 1'b0;
  logic       move = 1'b0;
  logic       wren = 1'b0;
  logic [2:0] draw_color = 3'd0;

  logic [7:0] x0, x1;
  logic [6:0] y0, y1;
  logic [2:0] col0, col1;
  logic       plot0, plot1, fin0, fin1;

  always #5 clk = ~clk;

  sprite_datapath #(.SIZE(S), .X_START(0), .Y_START(0), .X_MAX(XM), .Y_MAX(YM)) dut0 (
    .clk(clk), .resetn(resetn), .init(init), .move(move), .wren(wren),
    .draw_color(draw_color), .x(x0), .y(y0), .colour(col0), .plot(plot0), .finish(fin0));

  sprite_datapath #(.SIZE(S), .X_START(155), .Y_START(115), .X_MAX(XM), .Y_MAX(YM)) dut1 (
    .clk(clk), .resetn(resetn), .init(init), .move(move), .wren(wren),
    .draw_color(draw_color), .x(x1), .y(y1), .colour(col1), .plot(plot1), .finish(fin1));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: one entry per instance. k is the linear pixel index
  // of the sweep; column = k % S, row = k / S.
  int mpx[2], mpy[2], mdx[2], mdy[2], mk[2];
  int mx[2], my[2], mc[2], mp[2];
  int fin_s0, fin_s1;

  function automatic int start_x(input int i); return (i == 0) ? 0 : 155; endfunction
  function automatic int start_y(input int i); return (i == 0) ? 0 : 115; endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic bounce(inout int pos, inout int dir, input int lim);
    if (dir == 1 && pos + S == lim) begin dir = 0; pos = pos - 1; end
    else if (dir == 0 && pos == 0)  begin dir = 1; pos = pos + 1; end
    else pos = pos + (dir == 1 ? 1 : -1);
  endtask

  function automatic int model_fin(input int i, input bit r, input bit w);
    return (w && !r && mk[i] == S * S - 1) ? 1 : 0;
  endfunction

  task automatic model_edge(input bit r, input bit in, input bit m, input bit w, input int c);
    for (int i = 0; i < 2; i++) begin
      if (r) begin
        mpx[i] = start_x(i); mpy[i] = start_y(i); mdx[i] = 1; mdy[i] = 1; mk[i] = 0;
        mx[i] = 0; my[i] = 0; mc[i] = 0; mp[i] = 0;
      end else begin
        if (w) begin
          mx[i] = mpx[i] + mk[i] % S;
          my[i] = mpy[i] + mk[i] / S;
          mc[i] = c;
          mp[i] = 1;
          mk[i] = (mk[i] + 1) % (S * S);
        end else begin
          mk[i] = 0;
          mp[i] = 0;
        end
        if (in) begin
          mpx[i] = start_x(i); mpy[i] = start_y(i); mdx[i] = 1; mdy[i] = 1;
        end else if (m) begin
          bounce(mpx[i], mdx[i], XM);
          bounce(mpy[i], mdy[i], YM);
        end
      end
    end
  endtask

  // One clock: drive inputs, check finish before the edge, then check the
  // registered outputs of both instances just after the edge.
  task automatic cyc(input bit r, input bit in, input bit m, input bit w, input logic [2:0] c);
    resetn = r; init = in; move = m; wren = w; draw_color = c;
    #1;
    fin_s0 = int'(fin0);
    fin_s1 = int'(fin1);
    chk("finish0", fin_s0, model_fin(0, r, w));
    chk("finish1", fin_s1, model_fin(1, r, w));
    @(posedge clk);
    model_edge(r, in, m, w, int'(c));
    #1;
    chk("x0", int'(x0), mx[0]);     chk("y0", int'(y0), my[0]);
    chk("colour0", int'(col0), mc[0]); chk("plot0", int'(plot0), mp[0]);
    chk("x1", int'(x1), mx[1]);     chk("y1", int'(y1), my[1]);
    chk("colour1", int'(col1), mc[1]); chk("plot1", int'(plot1), mp[1]);
    if (plot0) chk("x0_in_screen", int'(x0 < 8'(XM) && y0 < 7'(YM)), 1);
    if (plot1) chk("x1_in_screen", int'(x1 < 8'(XM) && y1 < 7'(YM)), 1);
  endtask

  typedef struct {
    bit       w;
    bit [2:0] c;
    int       ef;
    int       ep;
    int       ex;
    int       ey;
    int       ec;
  } vec_t;

  vec_t tbl[17];

  initial begin
    bit r, in, m, w;
    logic [2:0] c;

    // Full sweep from origin (0,0), colour 100: row-major, finish on the
    // 16th wren cycle, then one idle cycle where x/y/colour hold.
    for (int i = 0; i < 16; i++)
      tbl[i] = '{w: 1'b1, c: 3'b100, ef: (i == 15) ? 1 : 0, ep: 1, ex: i % 4, ey: i / 4, ec: 4};
    tbl[16] = '{w: 1'b0, c: 3'b000, ef: 0, ep: 0, ex: 3, ey: 3, ec: 4};

    for (int i = 0; i < 2; i++) begin
      mpx[i] = 0; mpy[i] = 0; mdx[i] = 1; mdy[i] = 1; mk[i] = 0;
      mx[i] = 0; my[i] = 0; mc[i] = 0; mp[i] = 0;
    end

    // Reset with wren/move/init also asserted: reset wins.
    cyc(1, 1, 1, 1, 3'b111);
    cyc(1, 0, 0, 0, 3'b000);
    chk("rst_x0", int'(x0), 0);
    chk("rst_plot0", int'(plot0), 0);
    chk("rst_colour0", int'(col0), 0);

    // Table-driven full sweep.
    for (int i = 0; i < 17; i++) begin
      cyc(0, 0, 0, tbl[i].w, tbl[i].c);
      chk("tbl_finish", fin_s0, tbl[i].ef);
      chk("tbl_plot", int'(plot0), tbl[i].ep);
      chk("tbl_x", int'(x0), tbl[i].ex);
      chk("tbl_y", int'(y0), tbl[i].ey);
      chk("tbl_colour", int'(col0), tbl[i].ec);
    end

    // Interrupted sweep: 5 pixels, gap, then restart from (0,0).
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 3'b001);
    cyc(0, 0, 0, 0, 3'b001);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 3'b011);
      if (i == 0) begin chk("restart_x", int'(x0), 0); chk("restart_y", int'(y0), 0); end
      chk("restart_finish", fin_s0, (i == 15) ? 1 : 0);
    end
    cyc(0, 0, 0, 0, 3'b000);

    // init then three moves: next sweep spans (3,3)..(6,6).
    cyc(0, 1, 0, 0, 3'b000);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 3'b000);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 3'b010);
      if (i == 0)  begin chk("moved_first_x", int'(x0), 3); chk("moved_first_y", int'(y0), 3); end
      if (i == 15) begin chk("moved_last_x", int'(x0), 6); chk("moved_last_y", int'(y0), 6); end
    end
    cyc(0, 0, 0, 0, 3'b000);

    // Move origin to (5,5), then init and move together: init wins.
    cyc(0, 1, 0, 0, 3'b000);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 3'b000);
    cyc(0, 0, 0, 1, 3'b101);
    chk("at55_x", int'(x0), 5);
    cyc(0, 1, 1, 0, 3'b000);
    cyc(0, 0, 0, 1, 3'b101);
    chk("initmove_x0", int'(x0), 0);   chk("initmove_y0", int'(y0), 0);
    chk("initmove_x1", int'(x1), 155); chk("initmove_y1", int'(y1), 115);
    cyc(0, 0, 0, 0, 3'b000);

    // Reset mid-sweep at cnt=7 with wren held.
    for (int i = 0; i < 7; i++) cyc(0, 0, 0, 1, 3'b110);
    cyc(1, 0, 0, 1, 3'b110);
    chk("midrst_finish", fin_s0, 0);
    chk("midrst_plot", int'(plot0), 0);
    chk("midrst_x", int'(x0), 0);
    chk("midrst_y", int'(y0), 0);
    for (int i = 0; i < 16; i++) begin
      cyc(0, 0, 0, 1, 3'b110);
      if (i == 0) begin chk("postrst_x1", int'(x1), 155); chk("postrst_y1", int'(y1), 115); end
      chk("postrst_finish", fin_s0, (i == 15) ? 1 : 0);
    end
    cyc(0, 0, 0, 0, 3'b000);

    // Edge bounce on the (155,115) instance.
    cyc(1, 0, 0, 0, 3'b000);
    cyc(0, 0, 1, 0, 3'b000);
    cyc(0, 0, 0, 1, 3'b001);
    chk("edge1_x1", int'(x1), 156); chk("edge1_y1", int'(y1), 116);
    cyc(0, 0, 1, 0, 3'b000);
    cyc(0, 0, 0, 1, 3'b001);
    chk("edge2_x1", int'(x1), 155); chk("edge2_y1", int'(y1), 115);
    for (int i = 0; i < 155; i++) cyc(0, 0, 1, 0, 3'b000);
    cyc(0, 0, 0, 1, 3'b001);
    chk("zero_x1", int'(x1), 0);
    cyc(0, 0, 1, 0, 3'b000);
    cyc(0, 0, 0, 1, 3'b001);
    chk("rebound_x1", int'(x1), 1);
    cyc(0, 0, 0, 0, 3'b000);

    // Randomized traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      r  = ($urandom % 60) == 0;
      in = ($urandom % 50) == 0;
      m  = ($urandom % 4) == 0;
      w  = ($urandom % 10) < 8;
      c  = 3'($urandom);
      cyc(r, in, m, w, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
